// File: rtl/mips_pkg.sv
// Shared constants and types for the M3 memory-stage lane sequencer.
package mips_pkg;

  localparam int unsigned LANES = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;

  typedef enum logic {IDLE, SERVE} state_t;

  typedef logic [LANES-1:0] lane_mask_t;

endpackage

// File: rtl/lane_priority_pick.sv
// Lowest-set-bit picker: one-hot grant, its index, and whether it is the only bit set.
module lane_priority_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  mask,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          last
);

  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (mask[i] && !found) begin
        grant[i] = 1'b1;
        idx      = IW'(i);
        found    = 1'b1;
      end
    end
    last = found && ((mask & ~grant) == '0);
  end

endmodule

// File: rtl/dmem_lane_sequencer.sv
// Serializes the M3 loads/stores of a four-issue bundle onto the single data
// memory port in lane order, stalling the pipeline while more than one remains.
module dmem_lane_sequencer
  import mips_pkg::*;
#(
  parameter int unsigned LANES = mips_pkg::LANES,
  parameter int unsigned AW    = mips_pkg::AW,
  parameter int unsigned DW    = mips_pkg::DW
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [LANES-1:0]    memreqM3,
  input  logic [LANES-1:0]    memwriteM3,
  input  logic [LANES*AW-1:0] aluoutM3,
  input  logic [LANES*DW-1:0] writedataM3,
  input  logic                flushM3,
  output logic                we3,
  output logic [AW-1:0]       dataadrM3,
  output logic [DW-1:0]       writedata2M3,
  input  logic [DW-1:0]       readdata,
  output logic [LANES*DW-1:0] readdataM3,
  output logic                stallM3
);

  localparam int unsigned IW = (LANES > 1) ? $clog2(LANES) : 1;

  state_t           state;
  logic [LANES-1:0] pending;
  logic [LANES-1:0] src;
  logic [LANES-1:0] grant;
  logic [IW-1:0]    idx;
  logic             last;
  logic             any;
  logic [DW-1:0]    cap [LANES];

  // Reset masks the source so the port is quiet during the reset cycle itself.
  always_comb begin
    src = '0;
    if (!reset) src = (state == IDLE) ? memreqM3 : pending;
  end

  lane_priority_pick #(.N(LANES), .IW(IW)) u_pick (
    .mask  (src),
    .grant (grant),
    .idx   (idx),
    .last  (last)
  );

  always_comb begin
    any          = |src;
    we3          = any & memwriteM3[idx] & ~flushM3;
    dataadrM3    = any ? aluoutM3[AW*idx +: AW] : '0;
    writedata2M3 = any ? writedataM3[DW*idx +: DW] : '0;
    stallM3      = any & ~last & ~flushM3;
  end

  always_comb begin
    readdataM3 = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      readdataM3[DW*k +: DW] = grant[k] ? readdata : cap[k];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pending <= '0;
      for (int unsigned k = 0; k < LANES; k++) cap[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (grant[k] && !memwriteM3[k] && !flushM3) cap[k] <= readdata;
      end
      // stallM3 already folds in flush, so a low stall always means bundle done.
      if (stallM3) begin
        state   <= SERVE;
        pending <= src & ~grant;
      end else begin
        state   <= IDLE;
        pending <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_lane_sequencer.sv
// Directed bench: stimulus pushes per-cycle expected port values into a
// scoreboard queue, a negedge monitor pops and compares; a small memory model serves reads.
module tb_dmem_lane_sequencer;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    memreqM3;
  logic [3:0]    memwriteM3;
  logic [127:0]  aluoutM3;
  logic [127:0]  writedataM3;
  logic          flushM3;
  logic          we3;
  logic [31:0]   dataadrM3;
  logic [31:0]   writedata2M3;
  logic [31:0]   readdata;
  logic [127:0]  readdataM3;
  logic          stallM3;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] mem [64];

  typedef struct {
    logic            we;
    logic [31:0]     adr;
    logic [31:0]     wd;
    logic            stall;
    logic [3:0]      rdchk;
    logic [3:0][31:0] rd;
  } exp_t;

  exp_t sbq[$];

  dmem_lane_sequencer #(.LANES(4), .AW(32), .DW(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .memreqM3     (memreqM3),
    .memwriteM3   (memwriteM3),
    .aluoutM3     (aluoutM3),
    .writedataM3  (writedataM3),
    .flushM3      (flushM3),
    .we3          (we3),
    .dataadrM3    (dataadrM3),
    .writedata2M3 (writedata2M3),
    .readdata     (readdata),
    .readdataM3   (readdataM3),
    .stallM3      (stallM3)
  );

  always #5 clk = ~clk;

  assign readdata = mem[dataadrM3[7:2]];

  always @(posedge clk) begin
    if (we3) mem[dataadrM3[7:2]] <= writedata2M3;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic expect_cyc(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                            input logic stall, input logic [3:0] rdchk,
                            input logic [3:0][31:0] rd);
    exp_t e;
    e.we = we; e.adr = adr; e.wd = wd; e.stall = stall; e.rdchk = rdchk; e.rd = rd;
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic bundle(input logic [3:0] mr, input logic [3:0] mw,
                        input logic [3:0][31:0] a, input logic [3:0][31:0] d);
    memreqM3    = mr;
    memwriteM3  = mw;
    aluoutM3    = a;
    writedataM3 = d;
  endtask

  // Monitor: one scoreboard entry per cycle in which stimulus queued an expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("we3",          32'(we3),     32'(e.we));
        check("dataadrM3",    dataadrM3,    e.adr);
        check("writedata2M3", writedata2M3, e.wd);
        check("stallM3",      32'(stallM3), 32'(e.stall));
        for (int k = 0; k < 4; k++) begin
          if (e.rdchk[k]) check($sformatf("readdataM3[%0d]", k), readdataM3[32*k +: 32], e.rd[k]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][31:0] z;
    z = '0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    reset   = 1'b1;
    flushM3 = 1'b0;
    bundle(4'b1111, 4'b1111, {32'd12, 32'd8, 32'd4, 32'd0}, {32'd4, 32'd3, 32'd2, 32'd1});
    @(posedge clk); #1;

    // Reset cycle with requests present: port must stay quiet.
    expect_cyc(1'b0, 32'd0, 32'd0, 1'b0, 4'b0000, z);
    reset = 1'b0;
    bundle(4'b0000, 4'b0000, z, z);
    expect_cyc(1'b0, 32'd0, 32'd0, 1'b0, 4'b1111, z);

    // Single store in lane 2: same-cycle access, no stall.
    bundle(4'b0100, 4'b0100, {32'd0, 32'd84, 32'd0, 32'd0}, {32'd0, 32'd7, 32'd0, 32'd0});
    expect_cyc(1'b1, 32'd84, 32'd7, 1'b0, 4'b0000, z);
    bundle(4'b0000, 4'b0000, z, z);
    expect_cyc(1'b0, 32'd0, 32'd0, 1'b0, 4'b0000, z);
    check("mem84_single", mem[21], 32'd7);

    // Four stores: three stall cycles then the last access, idle on the fifth.
    bundle(4'b1111, 4'b1111, {32'd92, 32'd88, 32'd84, 32'd80}, {32'd4, 32'd3, 32'd2, 32'd1});
    expect_cyc(1'b1, 32'd80, 32'd1, 1'b1, 4'b0000, z);
    expect_cyc(1'b1, 32'd84, 32'd2, 1'b1, 4'b0000, z);
    expect_cyc(1'b1, 32'd88, 32'd3, 1'b1, 4'b0000, z);
    expect_cyc(1'b1, 32'd92, 32'd4, 1'b0, 4'b0000, z);
    bundle(4'b0000, 4'b0000, z, z);
    expect_cyc(1'b0, 32'd0, 32'd0, 1'b0, 4'b0000, z);
    check("mem92_four", mem[23], 32'd4);

    // Lane 0 stores 5 to 80, lane 3 loads 80: load sees the store, capture holds.
    bundle(4'b1001, 4'b0001, {32'd80, 32'd0, 32'd0, 32'd80}, {32'd0, 32'd0, 32'd0, 32'd5});
    expect_cyc(1'b1, 32'd80, 32'd5, 1'b1, 4'b0000, z);
    expect_cyc(1'b0, 32'd80, 32'd0, 1'b0, 4'b1000, {32'd5, 32'd0, 32'd0, 32'd0});
    bundle(4'b0000, 4'b0000, z, z);
    expect_cyc(1'b0, 32'd0, 32'd0, 1'b0, 4'b1000, {32'd5, 32'd0, 32'd0, 32'd0});
    expect_cyc(1'b0, 32'd0, 32'd0, 1'b0, 4'b1000, {32'd5, 32'd0, 32'd0, 32'd0});

    // Lanes 1 and 2 store to 84: higher lane wins.
    bundle(4'b0110, 4'b0110, {32'd0, 32'd84, 32'd84, 32'd0}, {32'd0, 32'd7, 32'd9, 32'd0});
    expect_cyc(1'b1, 32'd84, 32'd9, 1'b1, 4'b0000, z);
    expect_cyc(1'b1, 32'd84, 32'd7, 1'b0, 4'b0000, z);
    bundle(4'b0000, 4'b0000, z, z);
    expect_cyc(1'b0, 32'd0, 32'd0, 1'b0, 4'b0000, z);
    check("mem84_waw", mem[21], 32'd7);

    // Three stores, flush on the second cycle: no write, no stall, third never issued.
    bundle(4'b1011, 4'b1011, {32'd108, 32'd0, 32'd104, 32'd100}, {32'd13, 32'd0, 32'd12, 32'd11});
    expect_cyc(1'b1, 32'd100, 32'd11, 1'b1, 4'b0000, z);
    flushM3 = 1'b1;
    expect_cyc(1'b0, 32'd104, 32'd12, 1'b0, 4'b0000, z);
    flushM3 = 1'b0;
    bundle(4'b0000, 4'b0000, z, z);
    expect_cyc(1'b0, 32'd0, 32'd0, 1'b0, 4'b0000, z);
    expect_cyc(1'b0, 32'd0, 32'd0, 1'b0, 4'b0000, z);
    check("mem100_flush", mem[25], 32'd11);
    check("mem104_flush", mem[26], 32'd0);
    check("mem108_flush", mem[27], 32'd0);

    // Reset mid-SERVE: aborted bundle issues nothing further, pending cleared.
    bundle(4'b1111, 4'b1111, {32'd124, 32'd120, 32'd116, 32'd112}, {32'd24, 32'd23, 32'd22, 32'd21});
    expect_cyc(1'b1, 32'd112, 32'd21, 1'b1, 4'b0000, z);
    expect_cyc(1'b1, 32'd116, 32'd22, 1'b1, 4'b0000, z);
    reset = 1'b1;
    expect_cyc(1'b0, 32'd0, 32'd0, 1'b0, 4'b0000, z);
    reset = 1'b0;
    bundle(4'b0000, 4'b0000, z, z);
    expect_cyc(1'b0, 32'd0, 32'd0, 1'b0, 4'b1111, z);
    expect_cyc(1'b0, 32'd0, 32'd0, 1'b0, 4'b0000, z);
    check("mem116_rst", mem[29], 32'd22);
    check("mem120_rst", mem[30], 32'd0);
    check("mem124_rst", mem[31], 32'd0);

    @(posedge clk); #1;
    check("scoreboard_drain", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
